seq_shifter: RTL and testbench
==============================

// Module: seq_shifter
// PURPOSE
//  Parametrised multi-cycle shift/rotate/LFSR unit for the NPC execute stage.
//  Accepts one operation via valid/ready, shifts up to STEP bits per cycle, and holds the result under back-pressure.
//  Shares the 3-bit op map of the single-step shift register and fills the previously unused code 101.
// PARAMETERS
//  WIDTH    32                 data width; power of two, >= 4
//  STEP     1                  max bits shifted per cycle; 1..WIDTH/2
//  SHAMT_W  $clog2(WIDTH)      width of in_amt (derived, do not override)
//  TAPS     32'h8020_0003      LFSR feedback mask; feedback = ^(reg & TAPS)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        request valid
//  in_ready   out  1        unit can accept a request
//  in_op      in   3        operation code, see BEHAVIOUR
//  in_data    in   WIDTH    operand
//  in_amt     in   SHAMT_W  shift amount / LFSR step count
//  flush      in   1        synchronous abort
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_data   out  WIDTH    result
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, remaining count=0.
//  - Op codes:
//    - 000 CLR -> 0
//    - 001 LOAD -> in_data
//    - 010 ROR
//    - 011 ROL
//    - 100 SRA
//    - 101 SRL
//    - 110 LFSR: per step, reg = {fb, reg[WIDTH-1:1]}
//    - 111 SLL
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    - IDLE: in_ready=1. On in_valid & in_ready, latch op and data; rem=in_amt.
//      - Go to DONE if op is CLR or LOAD, or if in_amt==0.
//      - Otherwise go to RUN.
//    - RUN: each edge shifts k=min(STEP,rem) bits and sets rem-=k. Go to DONE when rem<=STEP.
//    - DONE: out_valid=1 and out_data held stable. On out_ready, go to IDLE.
//  - Latency from the accept edge to out_valid = max(1, ceil(in_amt/STEP)) cycles.
//    - LFSR with STEP>1 applies k sequential single-bit LFSR steps per cycle.
//  - in_ready is low in RUN and DONE; there is no overlap of a new accept with result drain.
//  - Shift arithmetic:
//    - SRA replicates MSB.
//    - SRL and SLL zero-fill.
//    - Rotates wrap with no loss.
//    - Each step is exact at the k=rem boundary.
//  - flush (any state): next edge forces IDLE, out_valid=0, rem=0; out_data keeps its last value.
//    - flush wins over a simultaneous in_valid or out_ready.
//  - rst_n low mid-operation: all state returns to reset values immediately; in-flight work is lost.
//  - out_valid falls on the edge where out_valid & out_ready are both 1.
// CONFIGURATION
//  Macro SEQ_SHIFTER_LFSR_EN:
//  - Defined: op 110 behaves as above.
//  - Undefined: no LFSR logic and TAPS is ignored; op 110 behaves as LOAD (result = in_data, latency 1).
// STRUCTURE
//  - Package seq_shifter_pkg:
//    - localparams for the eight op codes (OP_CLR..OP_SLL)
//    - FSM state encodings S_IDLE, S_RUN, S_DONE (2-bit)
//  - Sub-module seq_shift_step: combinational; inputs op, data, k; output data shifted by k (k<=STEP).
//    - The top instantiates it once inside the RUN datapath.
// TESTING  (WIDTH=8, TAPS=8'h1D unless stated)
//  1. STEP=1, SRA, din=8'h90, amt=3 -> out_valid 3 cycles after accept, out_data=8'hF2; busy high throughout.
//  2. STEP=2, ROL, din=8'hA5, amt=5 -> latency 3 cycles, out_data=8'hB4; STEP=1 gives the same value with latency 5.
//  3. LFSR, din=8'h01, amt=1, SEQ_SHIFTER_LFSR_EN on -> out_data=8'h80.
//     Macro off -> out_data=8'h01 after 1 cycle.
//  4. SRL, din=8'hFF, amt=0 -> out_data=8'hFF after 1 cycle.
//     Then hold out_ready=0 for 4 cycles -> out_valid and out_data stable, in_ready=0.
//  5. SLL, din=8'h0F, amt=7, assert flush in the 2nd RUN cycle -> IDLE next edge, out_valid never rises.
//     A following CLR request -> out_data=8'h00.
//  6. Drop rst_n asynchronously mid-RUN -> outputs take reset values before the next edge.
//     After release, ROR din=8'h01 amt=1 -> 8'h80.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Shared op-code map and FSM state encoding for the multi-cycle shift/rotate/LFSR unit.
package seq_shifter_pkg;

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ROR  = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_LFSR = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_step.sv
// Combinational shifter: applies k (<= STEP) single-bit steps of the selected op to data.
// LFSR stepping exists only when SEQ_SHIFTER_LFSR_EN is defined.
module seq_shift_step
    import seq_shifter_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               STEP    = 1,
    parameter int               SHAMT_W = $clog2(WIDTH),
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(32'h8020_0003)
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] k,
    output logic [WIDTH-1:0]   result
);

`ifndef SEQ_SHIFTER_LFSR_EN
    logic [WIDTH-1:0] unused_taps;
    assign unused_taps = TAPS;
`endif

    // Unrolled chain of single-bit steps; step i is active only while i < k.
    always_comb begin
        result = data;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k)) begin
                case (op)
                    OP_ROR:  result = {result[0], result[WIDTH-1:1]};
                    OP_ROL:  result = {result[WIDTH-2:0], result[WIDTH-1]};
                    OP_SRA:  result = {result[WIDTH-1], result[WIDTH-1:1]};
                    OP_SRL:  result = {1'b0, result[WIDTH-1:1]};
                    OP_SLL:  result = {result[WIDTH-2:0], 1'b0};
`ifdef SEQ_SHIFTER_LFSR_EN
                    OP_LFSR: result = {^(result & TAPS), result[WIDTH-1:1]};
`endif
                    default: result = result;
                endcase
            end
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate/LFSR unit with valid/ready handshakes on both sides.
// Define SEQ_SHIFTER_LFSR_EN to enable op 110 as an LFSR; otherwise it acts as LOAD.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               STEP    = 1,
    parameter int               SHAMT_W = $clog2(WIDTH),
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(32'h8020_0003)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_amt,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    localparam logic [SHAMT_W-1:0] STEP_W = SHAMT_W'(STEP);

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [2:0]         step_op;
    logic [WIDTH-1:0]   step_data, step_result;
    logic [SHAMT_W-1:0] step_amt, step_k;
    logic               is_direct;

    // The accept edge performs the first step, so latency is max(1, ceil(amt/STEP)).
    always_comb begin
        step_op   = (state_q == S_IDLE) ? in_op   : op_q;
        step_data = (state_q == S_IDLE) ? in_data : data_q;
        step_amt  = (state_q == S_IDLE) ? in_amt  : rem_q;
        step_k    = (step_amt < STEP_W) ? step_amt : STEP_W;
        is_direct = (in_op == OP_CLR) || (in_op == OP_LOAD) || (in_amt == '0)
`ifndef SEQ_SHIFTER_LFSR_EN
                    || (in_op == OP_LFSR)
`endif
                    ;
    end

    seq_shift_step #(
        .WIDTH  (WIDTH),
        .STEP   (STEP),
        .SHAMT_W(SHAMT_W),
        .TAPS   (TAPS)
    ) u_step (
        .op    (step_op),
        .data  (step_data),
        .k     (step_k),
        .result(step_result)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        if (flush) begin
            state_d = S_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d = in_op;
                        if (is_direct) begin
                            data_d  = (in_op == OP_CLR) ? '0 : in_data;
                            rem_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            data_d  = step_result;
                            rem_d   = in_amt - step_k;
                            state_d = (in_amt <= STEP_W) ? S_DONE : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    data_d = step_result;
                    rem_d  = rem_q - step_k;
                    if (rem_q <= STEP_W) state_d = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_CLR;
            data_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: two instances (STEP=1 and STEP=2, WIDTH=8, TAPS=8'h1D) share stimulus
// and are checked every cycle against a transaction-level model plus literal expectations.
module tb_seq_shifter;
    import seq_shifter_pkg::*;

    localparam int         W    = 8;
    localparam logic [7:0] TAPS = 8'h1D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_op = 3'b000;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_amt = 3'b000;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready [2];
    logic       out_valid [2];
    logic       busy [2];
    logic [7:0] out_data [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(W), .STEP(1), .TAPS(TAPS)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_op(in_op), .in_data(in_data), .in_amt(in_amt), .flush(flush),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]), .busy(busy[0]));

    seq_shifter #(.WIDTH(W), .STEP(2), .TAPS(TAPS)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_op(in_op), .in_data(in_data), .in_amt(in_amt), .flush(flush),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]), .busy(busy[1]));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] modelResult(input logic [2:0] op, input logic [7:0] x, input int a);
        logic [15:0] dbl;
        logic [15:0] tmp;
        logic [7:0]  r;
        dbl = {x, x};
        r   = x;
        case (op)
            OP_CLR:  r = 8'h00;
            OP_LOAD: r = x;
            OP_ROR:  begin tmp = dbl >> a; r = tmp[7:0]; end
            OP_ROL:  begin tmp = dbl << a; r = tmp[15:8]; end
            OP_SRA:  r = $signed(x) >>> a;
            OP_SRL:  r = x >> a;
            OP_SLL:  r = x << a;
            OP_LFSR: begin
`ifdef SEQ_SHIFTER_LFSR_EN
                for (int i = 0; i < a; i++) r = {^(r & TAPS), r[7:1]};
`else
                r = x;
`endif
            end
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic int modelLatency(input logic [2:0] op, input int a, input int step);
        bit direct;
        direct = (op == OP_CLR) || (op == OP_LOAD) || (a == 0);
`ifndef SEQ_SHIFTER_LFSR_EN
        direct = direct || (op == OP_LFSR);
`endif
        return direct ? 1 : (a + step - 1) / step;
    endfunction

    // Transaction-level model: a request either completes after its latency or is cancelled.
    bit         m_busy [2];
    bit         m_valid [2];
    bit         m_known [2];
    logic [7:0] m_data [2];
    logic [7:0] m_res [2];
    int         m_cnt [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 0; m_valid[d] = 0; m_known[d] = 1; m_data[d] = 8'h00; m_cnt[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int lat;
                if (flush) begin
                    m_busy[d] = 0; m_valid[d] = 0; m_cnt[d] = 0;
                end else if (!m_busy[d]) begin
                    if (in_valid) begin
                        lat       = modelLatency(in_op, int'(in_amt), d + 1);
                        m_res[d]  = modelResult(in_op, in_data, int'(in_amt));
                        m_busy[d] = 1;
                        if (lat == 1) begin
                            m_valid[d] = 1; m_data[d] = m_res[d]; m_known[d] = 1;
                        end else begin
                            m_cnt[d] = lat - 1; m_known[d] = 0;
                        end
                    end
                end else if (!m_valid[d]) begin
                    m_cnt[d]--;
                    if (m_cnt[d] == 0) begin
                        m_valid[d] = 1; m_data[d] = m_res[d]; m_known[d] = 1;
                    end
                end else if (out_ready) begin
                    m_valid[d] = 0; m_busy[d] = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("u%0d.in_ready", d + 1), 32'(in_ready[d]), 32'(!m_busy[d]));
                checkOutput($sformatf("u%0d.busy", d + 1), 32'(busy[d]), 32'(m_busy[d]));
                checkOutput($sformatf("u%0d.out_valid", d + 1), 32'(out_valid[d]), 32'(m_valid[d]));
                if (m_known[d])
                    checkOutput($sformatf("u%0d.out_data", d + 1), 32'(out_data[d]), 32'(m_data[d]));
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] x, input logic [2:0] a,
                                 input int hold, output int lat1, output int lat2,
                                 output logic [7:0] d1, output logic [7:0] d2);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_data = x; in_amt = a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat1 = -1; lat2 = -1; d1 = 8'h00; d2 = 8'h00;
        n = 1;
        while ((lat1 < 0 || lat2 < 0) && n <= 40) begin
            if (out_valid[0] && lat1 < 0) begin lat1 = n; d1 = out_data[0]; end
            if (out_valid[1] && lat2 < 0) begin lat2 = n; d2 = out_data[1]; end
            if (lat1 < 0 || lat2 < 0) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        checkOutput("result timeout", 32'(lat1 < 0 || lat2 < 0), 32'd0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic checkIdleReset(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s u%0d out_valid", tag, d + 1), 32'(out_valid[d]), 32'd0);
            checkOutput($sformatf("%s u%0d busy", tag, d + 1), 32'(busy[d]), 32'd0);
            checkOutput($sformatf("%s u%0d in_ready", tag, d + 1), 32'(in_ready[d]), 32'd1);
            checkOutput($sformatf("%s u%0d out_data", tag, d + 1), 32'(out_data[d]), 32'h00);
        end
    endtask

    initial begin
        int l1, l2;
        logic [7:0] r1, r2;

        #12;
        checkIdleReset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_SRA, 8'h90, 3'd3, 0, l1, l2, r1, r2);
        checkOutput("sra u1 latency", 32'(l1), 32'd3);
        checkOutput("sra u1 data", 32'(r1), 32'hF2);
        checkOutput("sra u2 latency", 32'(l2), 32'd2);

        applyStimulus(OP_ROL, 8'hA5, 3'd5, 1, l1, l2, r1, r2);
        checkOutput("rol u2 latency", 32'(l2), 32'd3);
        checkOutput("rol u2 data", 32'(r2), 32'hB4);
        checkOutput("rol u1 latency", 32'(l1), 32'd5);
        checkOutput("rol u1 data", 32'(r1), 32'hB4);

        applyStimulus(OP_LFSR, 8'h01, 3'd1, 0, l1, l2, r1, r2);
`ifdef SEQ_SHIFTER_LFSR_EN
        checkOutput("lfsr data", 32'(r1), 32'h80);
`else
        checkOutput("lfsr-off data", 32'(r1), 32'h01);
`endif
        checkOutput("lfsr latency", 32'(l1), 32'd1);

        // Zero-amount shift, then back-pressure for four cycles.
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_SRL; in_data = 8'hFF; in_amt = 3'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("srl0 latency-1 valid", 32'(out_valid[0]), 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
            checkOutput("hold out_valid", 32'(out_valid[0]), 32'd1);
            checkOutput("hold out_data", 32'(out_data[0]), 32'hFF);
            checkOutput("hold in_ready", 32'(in_ready[0]), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("drain out_valid", 32'(out_valid[0]), 32'd0);

        // Flush during the second RUN cycle.
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_SLL; in_data = 8'h0F; in_amt = 3'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush u1 busy", 32'(busy[0]), 32'd0);
        checkOutput("flush u2 in_ready", 32'(in_ready[1]), 32'd1);
        repeat (8) begin
            @(posedge clk);
            #1;
            checkOutput("flush u1 out_valid", 32'(out_valid[0]), 32'd0);
            checkOutput("flush u2 out_valid", 32'(out_valid[1]), 32'd0);
        end
        applyStimulus(OP_CLR, 8'h5A, 3'd4, 0, l1, l2, r1, r2);
        checkOutput("clr after flush", 32'(r1), 32'h00);

        // Asynchronous reset in the middle of a long operation.
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_SRA; in_data = 8'h80; in_amt = 3'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkIdleReset("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(OP_ROR, 8'h01, 3'd1, 0, l1, l2, r1, r2);
        checkOutput("ror after reset u1", 32'(r1), 32'h80);
        checkOutput("ror after reset u2", 32'(r2), 32'h80);

        for (int t = 0; t < 80; t++) begin
            logic [2:0] op;
            logic [7:0] x;
            logic [2:0] a;
            op = 3'($urandom_range(0, 7));
            x  = 8'($urandom);
            a  = 3'($urandom_range(0, 7));
            applyStimulus(op, x, a, int'($urandom_range(0, 2)), l1, l2, r1, r2);
            checkOutput($sformatf("rand op%0d x%0h a%0d u1", op, x, a), 32'(r1), 32'(modelResult(op, x, int'(a))));
            checkOutput($sformatf("rand op%0d lat u2", op), 32'(l2), 32'(modelLatency(op, int'(a), 2)));
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
